// File: rtl/logic_unit.sv
// Registered bitwise logic lane (AND/OR/XOR/XNOR) with XOR-style accumulator,
// zero/parity flags and a saturating handshake counter. Parity: LOGIC_UNIT_PARITY_EN.
module logic_unit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             parity,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] count
);

    // valid/ready: a transfer happens on a rising edge where valid && ready;
    // the producer holds its data while valid && !ready, and ready never depends on valid.
    logic             accept;
    logic             handshake;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] result;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign operand_b = acc_mode ? acc : b;

    always_comb begin
        result = '0;
        case (op)
            2'b00:   result = a & operand_b;
            2'b01:   result = a | operand_b;
            2'b10:   result = a ^ operand_b;
            default: result = ~(a ^ operand_b);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            zero      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            c         <= result;
            zero      <= (result == '0);
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    // Clear wins over the write-back; the same-cycle result still used the old acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (accept && acc_mode) begin
            acc <= result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (handshake && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (accept) begin
            parity <= ^result;
        end
    end
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit.sv
// Bench for logic_unit: vector table, hand-written corner sequences and random
// traffic checked against a truth-table reference model.
module tb_logic_unit;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             acc_mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             zero;
    logic             parity;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;

    logic             in_ready2;
    logic             out_valid2;
    logic [WIDTH-1:0] c2;
    logic             zero2;
    logic             parity2;
    logic [WIDTH-1:0] acc2;
    logic [1:0]       count2;

    logic_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .c(c), .zero(zero),
        .parity(parity), .acc(acc), .count(count)
    );

    // Narrow-counter instance shares all inputs; only its count is of interest.
    logic_unit #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .out_valid(out_valid2), .out_ready(out_ready), .c(c2), .zero(zero2),
        .parity(parity2), .acc(acc2), .count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic             m_ov;
    logic [WIDTH-1:0] m_c;
    logic             m_zero;
    logic             m_par;
    logic [WIDTH-1:0] m_acc;
    int               m_cnt;
    int               m_cnt2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Per-bit truth table lookup indexed by {a_bit, b_bit}
    function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [1:0] o);
        logic [3:0] tt;
        logic [WIDTH-1:0] r;
        case (o)
            2'b00:   tt = 4'b1000;
            2'b01:   tt = 4'b1110;
            2'b10:   tt = 4'b0110;
            default: tt = 4'b1001;
        endcase
        for (int i = 0; i < WIDTH; i++) r[i] = tt[{x[i], y[i]}];
        return r;
    endfunction

    function automatic logic exp_parity();
`ifdef LOGIC_UNIT_PARITY_EN
        return m_par;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_ov = 0; m_c = '0; m_zero = 0; m_par = 0; m_acc = '0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, out_valid, m_ov);
        chk({tag, ".c"}, c, m_c);
        chk({tag, ".zero"}, zero, m_zero);
        chk({tag, ".parity"}, parity, exp_parity());
        chk({tag, ".acc"}, acc, m_acc);
        chk({tag, ".count"}, count, m_cnt);
        chk({tag, ".count_sat"}, count2, m_cnt2);
    endtask

    // Drive one cycle (called 1 time unit after a rising edge), advance the model, check.
    task automatic step(input logic iv, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [1:0] ov, input logic am, input logic ac, input logic ordy,
                        input string tag);
        logic acc_ok, hs;
        logic [WIDTH-1:0] r;
        in_valid = iv; a = av; b = bv; op = ov; acc_mode = am; acc_clr = ac; out_ready = ordy;
        #1;
        chk({tag, ".in_ready"}, in_ready, !m_ov || ordy);
        acc_ok = iv && (!m_ov || ordy);
        hs     = m_ov && ordy;
        r      = ref_op(av, am ? m_acc : bv, ov);
        @(posedge clk);
        if (hs) begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (acc_ok) begin
            m_ov = 1; m_c = r; m_zero = (r == '0); m_par = ^r;
        end else if (hs) begin
            m_ov = 0;
        end
        if (ac) m_acc = '0;
        else if (acc_ok && am) m_acc = r;
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n = 0;
        in_valid = 0; a = '0; b = '0; op = 2'b00; acc_mode = 0; acc_clr = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic [1:0]       ov;
        logic             am;
        logic             ac;
        logic             ordy;
        logic [WIDTH-1:0] exp_c;
        logic [WIDTH-1:0] exp_acc;
        logic             exp_zero;
        logic             exp_par;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Truth table, accumulator clear, then XOR chain a=3,5,6
        vecs[0] = '{1, 4'b0011, 4'b0101, 2'b00, 0, 0, 1, 4'b0001, 4'h0, 0, 1};
        vecs[1] = '{1, 4'b0011, 4'b0101, 2'b01, 0, 0, 1, 4'b0111, 4'h0, 0, 1};
        vecs[2] = '{1, 4'b0011, 4'b0101, 2'b10, 0, 0, 1, 4'b0110, 4'h0, 0, 0};
        vecs[3] = '{1, 4'b0011, 4'b0101, 2'b11, 0, 0, 1, 4'b1001, 4'h0, 0, 0};
        vecs[4] = '{0, 4'h0,    4'h0,    2'b00, 0, 1, 1, 4'b1001, 4'h0, 0, 0};
        vecs[5] = '{1, 4'h3,    4'hF,    2'b10, 1, 0, 1, 4'h3,    4'h3, 0, 0};
        vecs[6] = '{1, 4'h5,    4'hF,    2'b10, 1, 0, 1, 4'h6,    4'h6, 0, 0};
        vecs[7] = '{1, 4'h6,    4'hF,    2'b10, 1, 0, 1, 4'h0,    4'h0, 1, 0};

        do_reset();
        chk("reset.out_valid", out_valid, 0);
        chk("reset.c", c, 0);
        chk("reset.zero", zero, 0);
        chk("reset.parity", parity, 0);
        chk("reset.acc", acc, 0);
        chk("reset.count", count, 0);
        chk("reset.in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].iv, vecs[i].av, vecs[i].bv, vecs[i].ov, vecs[i].am, vecs[i].ac,
                 vecs[i].ordy, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_c", i), c, vecs[i].exp_c);
            chk($sformatf("vec%0d.tbl_acc", i), acc, vecs[i].exp_acc);
            chk($sformatf("vec%0d.tbl_zero", i), zero, vecs[i].exp_zero);
`ifdef LOGIC_UNIT_PARITY_EN
            chk($sformatf("vec%0d.tbl_parity", i), parity, vecs[i].exp_par);
`else
            chk($sformatf("vec%0d.tbl_parity", i), parity, 0);
`endif
        end

        // Backpressure: 4'hA pending, downstream stalls for 3 cycles
        step(1, 4'hA, 4'h0, 2'b01, 0, 0, 1, "bp_load");
        chk("bp_load.c", c, 4'hA);
        begin
            int cnt_before;
            cnt_before = int'(count);
            for (int i = 0; i < 3; i++) begin
                step(1, 4'(i + 1), 4'h0, 2'b01, 0, 0, 0, $sformatf("bp_stall%0d", i));
                chk($sformatf("bp_stall%0d.c_hold", i), c, 4'hA);
                chk($sformatf("bp_stall%0d.count_hold", i), count, cnt_before);
            end
            step(1, 4'h5, 4'h0, 2'b01, 0, 0, 1, "bp_release");
            chk("bp_release.c_new", c, 4'h5);
            chk("bp_release.count_inc", count, cnt_before + 1);
            chk("bp_release.out_valid", out_valid, 1);
        end

        // Clear collision: acc=5, then OR with a=2 while clearing
        step(1, 4'h5, 4'h0, 2'b01, 1, 1, 1, "cc_prep_clr");
        step(1, 4'h5, 4'h0, 2'b01, 1, 0, 1, "cc_prep");
        chk("cc_prep.acc", acc, 4'h5);
        step(1, 4'h2, 4'h0, 2'b01, 1, 1, 1, "cc_hit");
        chk("cc_hit.c", c, 4'h7);
        chk("cc_hit.acc", acc, 4'h0);

        // Narrow counter saturation: 1, 2, 3, 3, 3
        do_reset();
        step(1, 4'h1, 4'h1, 2'b00, 0, 0, 1, "sat_first");
        for (int i = 0; i < 5; i++) begin
            step(1, 4'h1, 4'h1, 2'b00, 0, 0, 1, $sformatf("sat%0d", i));
            chk($sformatf("sat%0d.count2", i), count2, (i < 3) ? i + 1 : 3);
        end

        // Asynchronous reset between edges with a result pending
        step(1, 4'h7, 4'hE, 2'b10, 1, 0, 0, "ar_load");
        #2;
        rst_n = 0;
        #1;
        chk("async_rst.out_valid", out_valid, 0);
        chk("async_rst.c", c, 0);
        chk("async_rst.acc", acc, 0);
        chk("async_rst.count", count, 0);
        chk("async_rst.in_ready", in_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;

        // Random traffic, long enough to saturate the wide counter
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 4) != 0), $sformatf("rnd%0d", i));
        end
        chk("rnd.count_saturated", count, (1 << CNT_W) - 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/logic_unit.md
# logic_unit

Parametrised, registered bitwise logic unit for the 4-bit processor datapath. It computes AND/OR/XOR/XNOR of two WIDTH-bit operands behind a one-stage valid/ready pipeline register. It also provides an XOR-style accumulator mode (result written back into an internal register), a zero flag, an optional parity flag and a saturating completed-transaction counter. It sits between the decode stage and the writeback mux as the ALU's logic lane.

## Interface
- WIDTH, 4, operand/result width (≥1)
- CNT_W, 8, width of completed-transaction counter (≥1)
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction present
- in_ready  out  1  unit can accept input this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored when acc_mode=1)
- op  in  2  00 AND, 01 OR, 10 XOR, 11 XNOR
- acc_mode  in  1  use accumulator as operand B; write result back to accumulator
- acc_clr  in  1  synchronous accumulator clear
- out_valid  out  1  result registered and pending
- out_ready  in  1  downstream accepts result
- c  out  WIDTH  registered result
- zero  out  1  registered: c == 0
- parity  out  1  registered: ^c (see Configuration)
- acc  out  WIDTH  accumulator contents
- count  out  CNT_W  saturating count of output handshakes

## Operation
- Single clock (clk); reset asynchronous, active-low (rst_n); all state is cleared on rst_n low regardless of clk.
- Accept = in_valid && in_ready.
- On accept:
  - Operand B is acc when acc_mode=1, otherwise b.
  - Compute r = a op B (bitwise, WIDTH bits, no carry).
  - Register c<=r, zero<=(r==0), parity<=^r, out_valid<=1.
- If acc_mode=1 on accept: acc<=r, unless acc_clr is also asserted (see below).
- acc_clr=1 sets acc<=0 in that cycle, whether or not an input is accepted. In the same cycle as an accepted acc_mode transaction:
  - the transaction computes with the pre-clear acc;
  - c reflects that result;
  - acc ends at 0 (clear wins the write).
- Output handshake = out_valid && out_ready; it clears out_valid unless a new accept occurs in the same cycle (in that case out_valid stays 1 with the new data).
- While out_valid && !out_ready: c, zero and parity hold stable; no accept occurs.
- count increments by 1 on each output handshake and saturates at 2^CNT_W−1 (no wrap).
- Reset mid-transaction discards any pending result; no partial output is produced.

## Timing
- in_ready = !out_valid || out_ready (combinational from out_valid and out_ready; no combinational path from in_valid).
- Latency 1 cycle: accept at edge N → out_valid, c, zero and parity valid after edge N.
- Throughput one transaction per cycle while out_ready=1.
- Back-to-back acc_mode accepts chain: each uses acc as written by the previous accept (acc updates at the same edge as c).
- Reset values: out_valid=0, c=0, zero=0, parity=0, acc=0, count=0; in_ready=1 after reset.
- zero is 0 at reset (not 1), because no result is valid.

## Configuration
- LOGIC_UNIT_PARITY_EN defined: parity output computed and registered as described.
- LOGIC_UNIT_PARITY_EN undefined: no parity logic compiled; parity tied to 0 constantly. All other behaviour is identical.

## Test plan
- Exhaustive truth table, WIDTH=4, out_ready=1: a=4'b0011, b=4'b0101, op 00/01/10/11 → c=0001/0111/0110/1001 one cycle after each accept. zero=0 throughout; parity=1/1/0/0 (with macro).
- Accumulator chain: acc_clr pulse, then acc_mode=1, op=10 with a=3, 5, 6 on consecutive cycles → c=3, 6, 0 and acc=3, 6, 0; zero=1 on the third result.
- Backpressure: result 4'hA pending, out_ready=0 for 3 cycles with in_valid=1 and a changing → in_ready=0, c holds 4'hA, count unchanged. Raise out_ready → handshake, new input accepted the same cycle, count +1.
- Clear collision: acc=4'h5; accept acc_mode=1, op=01, a=4'h2 with acc_clr=1 → c=4'h7, acc=0 next cycle.
- Counter saturation with CNT_W=2: 5 output handshakes → count 1, 2, 3, 3, 3.
- Async reset mid-stream: assert rst_n=0 between edges while out_valid=1 → out_valid, c, acc and count go to 0 immediately, in_ready=1. Build without LOGIC_UNIT_PARITY_EN → parity stays 0 for c=4'b0001.
